// File: rtl/hex_word_serializer.sv
// Prints a NIBBLES-digit word as lowercase ASCII hex, most significant digit first, over valid/ready.
// Optional CR/LF terminator after each word when HEX_SER_CRLF_EN is defined.
module hex_word_serializer #(
    parameter int unsigned NIBBLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4*NIBBLES-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           out_char,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);
    localparam int unsigned DW = 4 * NIBBLES;
    localparam int unsigned CW = $clog2(NIBBLES + 1);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NIBBLES - 1);

`ifdef HEX_SER_CRLF_EN
    typedef enum logic [1:0] {IDLE, DIGIT, CR, LF} state_t;
`else
    typedef enum logic {IDLE, DIGIT} state_t;
`endif

    state_t          state_q, state_d;
    logic [DW-1:0]   sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      char_d;
    logic            valid_d;
    logic            ready_d;
    logic            busy_d;
    logic            xfer;
    logic [DW-1:0]   sr_shift;

    function automatic logic [7:0] to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + 8'(nib);
        else             return 8'h57 + 8'(nib);
    endfunction

    assign xfer     = out_valid && out_ready;
    assign sr_shift = sr_q << 4;

    // Next state and next registered outputs; everything holds unless a handshake occurs.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        char_d  = out_char;
        valid_d = out_valid;
        ready_d = in_ready;
        busy_d  = busy;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = DIGIT;
                    sr_d    = in_data;
                    cnt_d   = '0;
                    char_d  = to_ascii(in_data[DW-1 -: 4]);
                    valid_d = 1'b1;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            DIGIT: begin
                if (xfer) begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_DIGIT) begin
`ifdef HEX_SER_CRLF_EN
                        state_d = CR;
                        char_d  = 8'h0D;
`else
                        state_d = IDLE;
                        char_d  = 8'h00;
                        valid_d = 1'b0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
`endif
                    end else begin
                        char_d = to_ascii(sr_shift[DW-1 -: 4]);
                    end
                end
            end
`ifdef HEX_SER_CRLF_EN
            CR: begin
                if (xfer) begin
                    state_d = LF;
                    char_d  = 8'h0A;
                end
            end
            LF: begin
                if (xfer) begin
                    state_d = IDLE;
                    char_d  = 8'h00;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                char_d  = 8'h00;
                valid_d = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any word in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            out_char  <= 8'h00;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            out_char  <= char_d;
            out_valid <= valid_d;
            in_ready  <= ready_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: doc/hex_word_serializer.md
HEX_WORD_SERIALIZER -- requirements
Module: hex_word_serializer

Interface
REQ-001 Parameter NIBBLES, default 8: number of hex digits per word, legal range 1..16.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_data  input  4*NIBBLES  word to print, digit 0 = most significant nibble.
REQ-005 in_valid  input  1  in_data is valid.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 out_char  output  8  ASCII character.
REQ-008 out_valid  output  1  out_char is valid.
REQ-009 out_ready  input  1  sink accepts out_char.
REQ-010 busy  output  1  a word is being emitted.

Function
REQ-011 The FSM SHALL have states IDLE, DIGIT, CR and LF; CR and LF exist only per REQ-030.
REQ-012 in_ready SHALL be 1 only in IDLE.
REQ-013 A word SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; in_data is captured into a shift register, the digit counter is cleared, and the FSM enters DIGIT.
REQ-014 out_valid SHALL rise on the cycle after acceptance.
REQ-015 Latency from acceptance to the first character SHALL be one cycle.
REQ-016 In DIGIT, out_char SHALL be the registered ASCII of the current top nibble: 0-9 map to 0x30-0x39 and 10-15 map to 0x61-0x66 (lowercase).
REQ-017 A transfer SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-018 On each transfer in DIGIT, the shift register SHALL shift left by 4 bits and the counter SHALL increment.
REQ-019 After the transfer of digit NIBBLES-1, the FSM SHALL go to CR when CRLF is enabled, otherwise to IDLE.
REQ-020 While out_valid=1 and out_ready=0, out_char and out_valid SHALL hold stable with no state change.
REQ-021 out_valid SHALL be 0 in IDLE.
REQ-022 out_valid and out_char SHALL be driven from registers (no combinational path from out_ready).
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 in_valid asserted outside IDLE SHALL be ignored; the word stays pending upstream.
REQ-025 After a word's final transfer, IDLE SHALL last at least one cycle before the next acceptance, so minimum spacing is NIBBLES(+2)+1 cycles per word.
REQ-026 The counter SHALL be ceil(log2(NIBBLES+1)) bits wide and never wrap within a word.

Reset
REQ-027 While reset=1, the state SHALL be IDLE, out_valid=0, out_char=0x00, busy=0, and the shift register and counter SHALL be 0.
REQ-028 in_ready SHALL be 1 on the first edge after reset deassertion.
REQ-029 Reset asserted mid-word SHALL immediately abandon the word; no further characters of that word are emitted.

Configuration
REQ-030 Macro HEX_SER_CRLF_EN:
- Defined: after the last digit, CR emits 0x0D, then LF emits 0x0A, each under the same valid/ready rules, then the FSM returns to IDLE.
- Undefined: CR and LF states are not synthesized and words are emitted back-to-back with no terminator.

Verification
REQ-031 NIBBLES=8, in_data=0x1234ABCD, out_ready=1 -> out_char 0x31,0x32,0x33,0x34,0x61,0x62,0x63,0x64 on consecutive cycles, then 0x0D,0x0A if HEX_SER_CRLF_EN is defined, then in_ready=1.
REQ-032 in_data=0x0000F00F with out_ready toggling 1,0,0,1 -> out_char holds its value through the stall cycles; output sequence is 30 30 30 30 66 30 30 66 with no drop or duplicate.
REQ-033 Reset pulse after the third transfer of 0xDEADBEEF -> out_valid=0 within the reset cycle; no 0x64 emitted after; in_ready=1 after release; next word 0x00000001 prints from its first digit.
REQ-034 in_valid held high with words 0xFFFFFFFF then 0x00000000 -> the second word is accepted only after busy falls; output is eight 0x66 characters followed by eight 0x30 characters.
REQ-035 NIBBLES=2, in_data=0x9A -> output is 0x39,0x61 (plus CRLF if enabled); busy=1 for exactly the emission cycles.
